// File: rtl/fetch_sequencer_pkg.sv
// +--------------------------------------------------------------------+
// | fetch_sequencer_pkg: shared fetch constants, entry layout, states  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package fetch_sequencer_pkg;

  localparam int unsigned WORD_BYTES       = 4;
  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned ENTRY_W          = ADDR_W + DATA_W;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } q_state_e;

  function automatic q_state_e q_state_of(input int unsigned count, input int unsigned depth);
    if (count == 0) return Q_EMPTY;
    if (count >= depth) return Q_FULL;
    return Q_PARTIAL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_queue.sv
// +--------------------------------------------------------------------+
// | fetch_queue: DEPTH-entry sync FIFO, flush beats push/pop           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_queue #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: the read port is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = (count_q == '0) ? '0 : mem_q[head_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// +--------------------------------------------------------------------+
// | fetch_sequencer: fetch PC, prefetch queue and branch redirect      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = fetch_sequencer_pkg::ADDR_W,
  parameter int unsigned       DATA_W   = fetch_sequencer_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned       QDEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [DATA_W-1:0]         imem_instr,
  input  logic                      branch_taken,
  input  logic [ADDR_W-1:0]         branch_addr,
  input  logic                      id_ready,
  output logic                      id_valid,
  output logic [DATA_W-1:0]         id_instr,
  output logic [ADDR_W-1:0]         id_pc,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

  logic [ADDR_W-1:0]        fetch_pc_q;
  logic [ADDR_W-1:0]        fetch_pc_d;
  logic [ADDR_W+DATA_W-1:0] head_w;
  q_state_e                 q_state_w;
  logic                     pop_w;
  logic                     push_w;

  assign q_state_w = q_state_of(32'(q_count), QDEPTH);
  assign id_valid  = (q_state_w != Q_EMPTY);
  assign pop_w     = id_valid & id_ready & ~branch_taken;
  // A full queue may still accept a word in the same cycle its head drains.
  assign push_w    = ~branch_taken & ((q_state_w != Q_FULL) | (id_valid & id_ready));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (branch_taken)
      fetch_pc_d = branch_addr & ALIGN_MASK;
    else if (push_w)
      fetch_pc_d = fetch_pc_q + ADDR_W'(WORD_BYTES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_pc_q <= RESET_PC;
    else     fetch_pc_q <= fetch_pc_d;
  end

  fetch_queue #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_w),
    .pop_i   (pop_w),
    .flush_i (branch_taken),
    .wdata_i ({fetch_pc_q, imem_instr}),
    .rdata_o (head_w),
    .count_o (q_count)
  );

  assign imem_addr          = fetch_pc_q;
  assign {id_pc, id_instr}  = head_w;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; decode-side scoreboard of expected PCs.
`default_nettype none

module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [1:0]  q_count;

  int passed = 0;
  int total  = 0;
  logic [31:0] sb [$];

  fetch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .id_ready     (id_ready),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .q_count      (q_count)
  );

  assign imem_instr = imem_addr | 32'hE000_0000;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  // One clock: decode accepts at the negedge preview, then advance to posedge+1.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    if (id_valid && id_ready && !branch_taken) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("id_pc", 64'(id_pc), 64'(e));
        chk("id_instr", 64'(id_instr), 64'(e | 32'hE000_0000));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch_taken = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_instr", 64'(id_instr), 64'd0);
    chk("rst_pc", 64'(id_pc), 64'd0);
    chk("rst_count", 64'(q_count), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    id_ready = 1'b1;
    branch_taken = 1'b0;
    branch_addr = '0;

    // 1: reset release with decode always ready
    do_reset();
    push_seq(32'h0, 8);
    chk("t1_valid_before_fetch", 64'(id_valid), 64'd0);
    cycle();
    chk("t1_valid_after_fetch", 64'(id_valid), 64'd1);
    chk("t1_first_pc", 64'(id_pc), 64'd0);
    repeat (4) cycle();
    chk("t1_valid_sustained", 64'(id_valid), 64'd1);
    chk("t1_count", 64'(q_count), 64'd1);

    // 2: decode stalled, queue saturates, then drains without gap
    do_reset();
    id_ready = 1'b0;
    push_seq(32'h0, 8);
    repeat (5) cycle();
    chk("t2_count_full", 64'(q_count), 64'd2);
    chk("t2_imem_addr", 64'(imem_addr), 64'h8);
    chk("t2_head_hold", 64'(id_pc), 64'h0);
    id_ready = 1'b1;
    repeat (3) cycle();
    chk("t2_count_after", 64'(q_count), 64'd2);
    chk("t2_imem_after", 64'(imem_addr), 64'd20);

    // 3: branch to misaligned target while full
    id_ready = 1'b0;
    cycle();
    branch_taken = 1'b1;
    branch_addr = 32'h103;
    cycle();
    chk("t3_valid", 64'(id_valid), 64'd0);
    chk("t3_count", 64'(q_count), 64'd0);
    chk("t3_imem_addr", 64'(imem_addr), 64'h100);
    chk("t3_empty_pc", 64'(id_pc), 64'd0);
    chk("t3_empty_instr", 64'(id_instr), 64'd0);
    sb.delete();
    push_seq(32'h100, 8);
    branch_taken = 1'b0;
    id_ready = 1'b1;
    cycle();
    chk("t3_valid_next", 64'(id_valid), 64'd1);
    repeat (2) cycle();

    // 4: branch while head is being accepted, then back-to-back branch
    chk("t4_pre_valid", 64'(id_valid), 64'd1);
    branch_taken = 1'b1;
    branch_addr = 32'h200;
    cycle();
    chk("t4_valid", 64'(id_valid), 64'd0);
    chk("t4_count", 64'(q_count), 64'd0);
    chk("t4_imem_addr", 64'(imem_addr), 64'h200);
    branch_addr = 32'h300;
    cycle();
    chk("t4_b2b_imem_addr", 64'(imem_addr), 64'h300);
    chk("t4_b2b_count", 64'(q_count), 64'd0);
    sb.delete();
    push_seq(32'h300, 4);
    branch_taken = 1'b0;
    repeat (2) cycle();

    // 5: fetch PC wraps past the top of the address space
    branch_taken = 1'b1;
    branch_addr = 32'hFFFF_FFFC;
    cycle();
    chk("t5_imem_addr", 64'(imem_addr), 64'hFFFF_FFFC);
    sb.delete();
    push_seq(32'hFFFF_FFFC, 4);
    branch_taken = 1'b0;
    repeat (4) cycle();

    // 6: asynchronous reset with a full queue
    id_ready = 1'b0;
    repeat (3) cycle();
    chk("t6_count_full", 64'(q_count), 64'd2);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 64'(id_valid), 64'd0);
    chk("t6_async_pc", 64'(id_pc), 64'd0);
    chk("t6_async_instr", 64'(id_instr), 64'd0);
    chk("t6_async_count", 64'(q_count), 64'd0);
    chk("t6_async_imem", 64'(imem_addr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    push_seq(32'h0, 4);
    id_ready = 1'b1;
    repeat (3) cycle();
    chk("t6_restart_pc", 64'(id_pc), 64'h8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
